// File: rtl/updi_pkg.sv
// updi_pkg: shared states, result codes and the SYNCH byte for the UPDI link sequencer
package updi_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, SEND, ECHO, RECV, BREAK, DONE} link_state_e;
  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_ECHO_ERR  = 3'd1,
    ST_FRAME_ERR = 3'd2,
    ST_TIMEOUT   = 3'd3,
    ST_BREAK_OK  = 3'd4
  } status_e;
  localparam logic [7:0] UPDI_SYNCH = 8'h55;
endpackage

// File: rtl/updi_link_ctrl_if.sv
// updi_link_ctrl_if: command, payload, response and UART-side signals of the link sequencer
interface updi_link_ctrl_if;
  logic       cmd_valid, cmd_ready, cmd_break;
  logic [3:0] cmd_tx_len, cmd_rx_len;
  logic [7:0] txb_data;
  logic       txb_valid, txb_ready;
  logic [7:0] rxb_data;
  logic       rxb_valid, done;
  logic [2:0] status;
  logic [7:0] u_tx_data, u_rx_data;
  logic       u_transmit_start, u_transmit_ready, u_rx_data_valid, u_rx_error;
  logic       break_active;
  modport master (
    output cmd_valid, cmd_tx_len, cmd_rx_len, cmd_break, txb_data, txb_valid,
           u_transmit_ready, u_rx_data, u_rx_data_valid, u_rx_error,
    input  cmd_ready, txb_ready, rxb_data, rxb_valid, done, status,
           u_tx_data, u_transmit_start, break_active
  );
  modport slave (
    input  cmd_valid, cmd_tx_len, cmd_rx_len, cmd_break, txb_data, txb_valid,
           u_transmit_ready, u_rx_data, u_rx_data_valid, u_rx_error,
    output cmd_ready, txb_ready, rxb_data, rxb_valid, done, status,
           u_tx_data, u_transmit_start, break_active
  );
endinterface

// File: rtl/updi_timer.sv
// updi_timer: loadable down-counter; expired_o marks the last cycle before the count hits zero
module updi_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? value_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign expired_o = cnt_q == W'(1);
endmodule

// File: rtl/updi_link_ctrl.sv
// updi_link_ctrl: sends SYNCH + payload over a half-duplex UART, checks echoes,
// collects the response and forces BREAK recovery on any link fault
module updi_link_ctrl
  import updi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int BREAK_CYCLES   = 4096
) (
  input logic             clk,
  input logic             rst_n,
  updi_link_ctrl_if.slave bus
);
  localparam int TW = $clog2((TIMEOUT_CYCLES > BREAK_CYCLES ? TIMEOUT_CYCLES : BREAK_CYCLES) + 1);
  link_state_e state_q, state_d;
  status_e     status_q, status_d;
  logic [3:0]  tx_len_q, tx_len_d, rx_len_q, rx_len_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d, rxb_data_q, rxb_data_d;
  logic        start_q, start_d, rxb_valid_q, rxb_valid_d;
  logic        tmr_load, tmr_exp;
  logic [TW-1:0] tmr_val;
  updi_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load_i(tmr_load), .value_i(tmr_val), .expired_o(tmr_exp)
  );
  // tx_data_q doubles as the expected echo byte
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    tx_len_d    = tx_len_q;
    rx_len_d    = rx_len_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    tx_data_d   = tx_data_q;
    rxb_data_d  = rxb_data_q;
    start_d     = 1'b0;
    rxb_valid_d = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        tx_len_d = bus.cmd_tx_len;
        rx_len_d = bus.cmd_rx_len;
        tx_cnt_d = '0;
        rx_cnt_d = '0;
        status_d = bus.cmd_break ? ST_BREAK_OK : ST_OK;
        state_d  = bus.cmd_break ? BREAK : SYNC;
      end
      SYNC: if (bus.u_transmit_ready) begin
        tx_data_d = UPDI_SYNCH;
        start_d   = 1'b1;
        state_d   = ECHO;
      end
      SEND: if (bus.txb_valid && bus.u_transmit_ready) begin
        tx_data_d = bus.txb_data;
        start_d   = 1'b1;
        tx_cnt_d  = tx_cnt_q + 4'd1;
        state_d   = ECHO;
      end
      ECHO: if (bus.u_rx_error) begin
        status_d = ST_FRAME_ERR;
        state_d  = BREAK;
      end else if (bus.u_rx_data_valid) begin
        if (bus.u_rx_data != tx_data_q) begin
          status_d = ST_ECHO_ERR;
          state_d  = BREAK;
        end else
          state_d = tx_cnt_q < tx_len_q ? SEND : (rx_len_q != '0 ? RECV : DONE);
      end else if (tmr_exp) begin
        status_d = ST_TIMEOUT;
        state_d  = BREAK;
      end
      RECV: if (bus.u_rx_error) begin
        status_d = ST_FRAME_ERR;
        state_d  = BREAK;
      end else if (bus.u_rx_data_valid) begin
        rxb_data_d  = bus.u_rx_data;
        rxb_valid_d = 1'b1;
        rx_cnt_d    = rx_cnt_q + 4'd1;
        if (rx_cnt_d == rx_len_q) state_d = DONE;
      end else if (tmr_exp) begin
        status_d = ST_TIMEOUT;
        state_d  = BREAK;
      end
      BREAK: if (tmr_exp) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // one timer serves the echo/response timeout and the BREAK length
    tmr_load = state_d != state_q || rxb_valid_d;
    tmr_val  = state_d == BREAK ? TW'(BREAK_CYCLES) : TW'(TIMEOUT_CYCLES);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      status_q    <= ST_OK;
      tx_len_q    <= '0;
      rx_len_q    <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      tx_data_q   <= '0;
      rxb_data_q  <= '0;
      start_q     <= 1'b0;
      rxb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      tx_len_q    <= tx_len_d;
      rx_len_q    <= rx_len_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_data_q   <= tx_data_d;
      rxb_data_q  <= rxb_data_d;
      start_q     <= start_d;
      rxb_valid_q <= rxb_valid_d;
    end
  assign bus.cmd_ready        = state_q == IDLE;
  assign bus.txb_ready        = state_q == SEND && bus.u_transmit_ready;
  assign bus.rxb_data         = rxb_data_q;
  assign bus.rxb_valid        = rxb_valid_q;
  assign bus.done             = state_q == DONE;
  assign bus.status           = status_q;
  assign bus.u_tx_data        = tx_data_q;
  assign bus.u_transmit_start = start_q;
  assign bus.break_active     = state_q == BREAK;
endmodule

// File: doc/updi_link_ctrl.md
Name: updi_link_ctrl

Overview:
- Transaction sequencer that sits between the UPDI instruction layer and the `uart` block.
- Each accepted command does the following, in order:
  - prepends the SYNCH byte (0x55);
  - streams N instruction/operand bytes to the UART transmitter;
  - checks each half-duplex echo;
  - collects M response bytes.
- Detects echo mismatch, frame errors and timeouts.
- Drives a BREAK request so the top level can force the line low for recovery.

Parameters:
- TIMEOUT_CYCLES, 65536: max clk cycles waiting for any echo or response byte.
- BREAK_CYCLES, 4096: clk cycles `break_active` is held high.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_tx_len  in  4  payload bytes after SYNCH (0-15)
- cmd_rx_len  in  4  response bytes expected (0-15)
- cmd_break  in  1  issue BREAK only; lengths ignored
- txb_data  in  8  payload byte stream
- txb_valid  in  1  payload byte valid
- txb_ready  out  1  payload byte accepted this cycle
- rxb_data  out  8  response byte
- rxb_valid  out  1  one-cycle pulse; no backpressure
- done  out  1  one-cycle pulse at end of command
- status  out  3  result code, valid when done=1
- u_tx_data  out  8  to uart tx_data
- u_transmit_start  out  1  to uart transmit_start
- u_transmit_ready  in  1  from uart transmit_ready
- u_rx_data  in  8  from uart rx_data
- u_rx_data_valid  in  1  from uart rx_data_valid
- u_rx_error  in  1  from uart rx_error
- break_active  out  1  top level forces the line low while high

Behaviour:
- Reset values while rst=0:
  - state IDLE, counters 0, cmd_ready=1.
  - All other outputs 0: txb_ready, rxb_data, rxb_valid, done, status, u_tx_data, u_transmit_start, break_active.
- Reset mid-transaction aborts immediately with no done pulse; bytes partially consumed from txb are lost.
- Command accept: on cmd_valid & cmd_ready, latch tx_len, rx_len and cmd_break.
  - cmd_break=1: go to BREAK.
  - Otherwise go to SYNC.
- SYNC:
  - When u_transmit_ready=1, register u_tx_data=0x55 and exp=0x55.
  - Pulse u_transmit_start for exactly one cycle (the next cycle), then go to ECHO.
- SEND:
  - txb_ready = u_transmit_ready (combinational) while in SEND.
  - On txb handshake: register the byte into u_tx_data and exp, pulse u_transmit_start the next cycle, tx_cnt++, go to ECHO.
  - u_transmit_start is never asserted while u_transmit_ready=0.
- ECHO (timer loaded with TIMEOUT_CYCLES on entry):
  - u_rx_data_valid with u_rx_data==exp:
    - if tx_cnt<tx_len, go to SEND;
    - else if rx_len>0, go to RECV;
    - else go to DONE with status OK.
  - Mismatch: status ECHO_ERR, go to BREAK.
  - u_rx_error: status FRAME_ERR, go to BREAK.
  - Timer expiry: status TIMEOUT, go to BREAK.
- RECV:
  - Timer reloaded on entry and on each byte.
  - Each u_rx_data_valid without error: rxb_data=u_rx_data, rxb_valid pulses the next cycle, rx_cnt++.
  - rx_cnt==rx_len: go to DONE with status OK.
  - u_rx_error: FRAME_ERR, go to BREAK. Timeout: TIMEOUT, go to BREAK.
- Simultaneous events: u_rx_error and u_rx_data_valid in the same cycle count as error. Timer expiry in the same cycle as a valid byte: the byte wins.
- BREAK:
  - break_active=1 for exactly BREAK_CYCLES cycles, then go to DONE.
  - Status is kept if already set by an error; otherwise (cmd_break) status is BREAK_OK.
  - UART rx bytes arriving during BREAK are ignored.
- DONE: one cycle, done=1 with status, then go to IDLE. cmd_ready returns the following cycle.
- IDLE: u_rx_data_valid and u_rx_error are ignored (stray bytes dropped).
- Status codes: 0 OK, 1 ECHO_ERR, 2 FRAME_ERR, 3 TIMEOUT, 4 BREAK_OK.
- Timer width: $clog2(max(TIMEOUT_CYCLES, BREAK_CYCLES)+1). "Expiry" is the cycle the count reaches 0.

Decomposition:
- Package updi_pkg holds:
  - the link_state enum (IDLE, SYNC, SEND, ECHO, RECV, BREAK, DONE);
  - the status enum (values above);
  - localparam UPDI_SYNCH = 8'h55.
- One sub-module: updi_timer, a down-counter with a load port (load, value, expired), shared for the echo/response timeout and the BREAK duration.

Test Plan:
- tx_len=2 {0x80,0x05}, rx_len=1, echoes looped back, response 0x1E -> UART sees 0x55,0x80,0x05; rxb_valid once with 0x1E; done with status=0.
- tx_len=0, rx_len=0 -> only 0x55 sent; done with status 0 one cycle after the echo-handling cycle.
- Echo of the 2nd byte corrupted (0x05 returned as 0x04) -> status=1; break_active high exactly BREAK_CYCLES cycles; done after.
- rx_len=2, no response bytes, TIMEOUT_CYCLES=100 -> break_active rises 100 cycles after entering RECV; status=3.
- u_rx_error asserted together with u_rx_data_valid during RECV -> status=2, no rxb_valid pulse.
- cmd_break=1 -> no u_transmit_start; break_active held BREAK_CYCLES cycles; status=4. Then assert rst low mid-SEND on the next command -> all outputs 0 and cmd_ready=1 immediately, no done pulse.
